// File: rtl/opfetch_pkg.sv
// Shared types and defaults for the operand fetch stage.
// No logic; constants only.
// No handshake; consumed by operand_fetch, operand_shifter and operand_fetch_if.
//
// Contents: FSM state encoding, B-operand shift op codes, default widths.
package opfetch_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_NREGS = 8;
    localparam int DEF_IMM_W = 5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        READ_A  = 2'd1,
        READ_B  = 2'd2,
        PRESENT = 2'd3
    } state_t;

    localparam logic [1:0] SH_NONE = 2'b00;
    localparam logic [1:0] SH_LSL  = 2'b01;
    localparam logic [1:0] SH_LSR  = 2'b10;
    localparam logic [1:0] SH_ASR  = 2'b11;

endpackage

// File: rtl/operand_fetch_if.sv
// Bundle of request, register-write and ALU-side operand signals.
// No logic, no latency.
// out_valid/out_ready carry the operand handshake; start is ignored while busy.
//
// Signals: write/writenum/data_in (register write), start/rn/rm/shift/asel/bsel/imm
// (fetch request), out_valid/out_ready/Ain/Bin (operands to ALU), busy (status).
// master: drives requests and out_ready. slave: the operand_fetch block.
interface operand_fetch_if
    import opfetch_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NREGS = DEF_NREGS,
    parameter int IMM_W = DEF_IMM_W
);
    localparam int IDX_W = $clog2(NREGS);

    logic             write;
    logic [IDX_W-1:0] writenum;
    logic [WIDTH-1:0] data_in;
    logic             start;
    logic [IDX_W-1:0] rn;
    logic [IDX_W-1:0] rm;
    logic [1:0]       shift;
    logic             asel;
    logic             bsel;
    logic [IMM_W-1:0] imm;
    logic             out_ready;
    logic             out_valid;
    logic [WIDTH-1:0] Ain;
    logic [WIDTH-1:0] Bin;
    logic             busy;

    modport master (
        output write, writenum, data_in, start, rn, rm, shift, asel, bsel, imm, out_ready,
        input  out_valid, Ain, Bin, busy
    );

    modport slave (
        input  write, writenum, data_in, start, rn, rm, shift, asel, bsel, imm, out_ready,
        output out_valid, Ain, Bin, busy
    );

endinterface

// File: rtl/operand_fetch_shifter.sv
// Single-bit shifter applied to the B operand (pass, LSL, LSR, ASR).
// Combinational, zero latency.
// No handshake.
//
// Ports: in (WIDTH) operand, shift (2) op code, out (WIDTH) shifted result; no carry out.
module operand_shifter
    import opfetch_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] in,
    input  logic [1:0]       shift,
    output logic [WIDTH-1:0] out
);

    always_comb begin
        out = in;
        case (shift)
            SH_NONE: out = in;
            SH_LSL:  out = {in[WIDTH-2:0], 1'b0};
            SH_LSR:  out = {1'b0, in[WIDTH-1:1]};
            SH_ASR:  out = {in[WIDTH-1], in[WIDTH-1:1]};
            default: out = in;
        endcase
    end

endmodule

// File: rtl/operand_fetch.sv
// Register file plus two-cycle operand fetch feeding the ALU's Ain/Bin pair.
// Start sampled in IDLE; out_valid rises three edges later; one fetch per 4 cycles.
// Holds Ain/Bin stable in PRESENT until out_ready; start while busy is dropped.
//
// Ports: clk, reset (synchronous, active-high), bus (operand_fetch_if.slave):
//   write/writenum/data_in, start/rn/rm/shift/asel/bsel/imm, out_ready -> out_valid/Ain/Bin, busy.
// Build option: define OPERAND_FETCH_BYPASS_EN to forward a same-cycle write into the read latch.
module operand_fetch
    import opfetch_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NREGS = DEF_NREGS,
    parameter int IMM_W = DEF_IMM_W
) (
    input  logic            clk,
    input  logic            reset,
    operand_fetch_if.slave  bus
);

    localparam int IDX_W = $clog2(NREGS);

    logic [WIDTH-1:0] rf [NREGS];

    state_t state_q, state_d;

    // Controls captured when a fetch is accepted.
    logic [IDX_W-1:0] rn_q, rm_q;
    logic [1:0]       shift_q;
    logic             asel_q, bsel_q;
    logic [IMM_W-1:0] imm_q;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] ain_q, bin_q;

    logic [IDX_W-1:0] rd_idx;
    logic [WIDTH-1:0] rd_dat;
    logic [WIDTH-1:0] b_shifted;

    // One read port, time-shared: rn during READ_A, rm during READ_B.
    assign rd_idx = (state_q == READ_B) ? rm_q : rn_q;

    always_comb begin
        rd_dat = rf[rd_idx];
`ifdef OPERAND_FETCH_BYPASS_EN
        if (bus.write && (bus.writenum == rd_idx)) begin
            rd_dat = bus.data_in;
        end
`else
`endif
    end

    // The raw B value only exists on its way through the shifter into bin_q,
    // so the B latch and the Bin register are the same flop.
    operand_shifter #(.WIDTH(WIDTH)) u_shift (
        .in    (rd_dat),
        .shift (shift_q),
        .out   (b_shifted)
    );

    always_comb begin
        state_d       = state_q;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b1;
        case (state_q)
            IDLE: begin
                bus.busy = 1'b0;
                if (bus.start) state_d = READ_A;
            end
            READ_A:  state_d = READ_B;
            READ_B:  state_d = PRESENT;
            PRESENT: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.Ain = ain_q;
    assign bus.Bin = bin_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            for (int i = 0; i < NREGS; i++) begin
                rf[i] <= '0;
            end
            rn_q    <= '0;
            rm_q    <= '0;
            shift_q <= SH_NONE;
            asel_q  <= 1'b0;
            bsel_q  <= 1'b0;
            imm_q   <= '0;
            a_q     <= '0;
            ain_q   <= '0;
            bin_q   <= '0;
        end else begin
            state_q <= state_d;

            // Array write is the same in both builds; reads above see the old
            // contents unless forwarding is built in.
            if (bus.write) begin
                rf[bus.writenum] <= bus.data_in;
            end

            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        rn_q    <= bus.rn;
                        rm_q    <= bus.rm;
                        shift_q <= bus.shift;
                        asel_q  <= bus.asel;
                        bsel_q  <= bus.bsel;
                        imm_q   <= bus.imm;
                    end
                end
                READ_A: begin
                    a_q <= rd_dat;
                end
                READ_B: begin
                    ain_q <= asel_q ? '0 : a_q;
                    bin_q <= bsel_q ? {{(WIDTH-IMM_W){1'b0}}, imm_q} : b_shifted;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch with a cycle-timeline reference model.
// Inputs driven 1 time unit after posedge; outputs checked on negedge.
// out_ready held high except in the backpressure scenario.
module tb_operand_fetch;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    operand_fetch_if #(.WIDTH(16), .NREGS(8), .IMM_W(5)) bus ();

    operand_fetch #(.WIDTH(16), .NREGS(8), .IMM_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Timeline view: a fetch accepted at cycle acc reads rn at cycle acc+1,
    // rm at cycle acc+2, then presents until a cycle with out_ready.
    logic [15:0] mr [8];
    int          cyc = 0;
    int          acc = 0;
    bit          m_act = 1'b0;
    bit          m_valid = 1'b0;
    logic [2:0]  c_rn, c_rm;
    logic [1:0]  c_sh;
    bit          c_as, c_bs;
    logic [4:0]  c_imm;
    logic [15:0] m_a, m_ain = '0, m_bin = '0;

    function automatic logic [15:0] sh_fn(input logic [15:0] v, input logic [1:0] op);
        case (op)
            2'd0:    return v;
            2'd1:    return v << 1;
            2'd2:    return v >> 1;
            default: return (v >> 1) | (v & 16'h8000);
        endcase
    endfunction

    function automatic logic [15:0] rd(input logic [2:0] idx);
`ifdef OPERAND_FETCH_BYPASS_EN
        if (bus.write && bus.writenum == idx) return bus.data_in;
`endif
        return mr[idx];
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            foreach (mr[i]) mr[i] = '0;
            m_act   = 1'b0;
            m_valid = 1'b0;
            m_ain   = '0;
            m_bin   = '0;
        end else begin
            if (!m_act) begin
                if (bus.start) begin
                    m_act = 1'b1; acc = cyc;
                    c_rn = bus.rn; c_rm = bus.rm; c_sh = bus.shift;
                    c_as = bus.asel; c_bs = bus.bsel; c_imm = bus.imm;
                end
            end else if (cyc == acc + 1) begin
                m_a = rd(c_rn);
            end else if (cyc == acc + 2) begin
                m_ain   = c_as ? 16'd0 : m_a;
                m_bin   = c_bs ? {11'd0, c_imm} : sh_fn(rd(c_rm), c_sh);
                m_valid = 1'b1;
            end else if (m_valid && bus.out_ready) begin
                m_act   = 1'b0;
                m_valid = 1'b0;
            end
            if (bus.write) mr[bus.writenum] = bus.data_in;
        end
    end

    always @(negedge clk) begin
        if (chk_on && !reset) begin
            chk("cyc_valid", {31'd0, bus.out_valid}, {31'd0, m_valid});
            chk("cyc_busy", {31'd0, bus.busy}, {31'd0, m_act});
            if (m_valid) begin
                chk("cyc_ain", {16'd0, bus.Ain}, {16'd0, m_ain});
                chk("cyc_bin", {16'd0, bus.Bin}, {16'd0, m_bin});
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wr(input logic [2:0] idx, input logic [15:0] val);
        bus.write = 1'b1; bus.writenum = idx; bus.data_in = val;
        @(posedge clk); #1;
        bus.write = 1'b0;
    endtask

    // Issues one fetch; returns the number of edges (from the start-sampling
    // edge) until out_valid is seen, or 0 if it never appears.
    task automatic fetch(input logic [2:0] rn, input logic [2:0] rm, input logic [1:0] sh,
                         input bit as, input bit bs, input logic [4:0] im,
                         input bit wr_a, input logic [2:0] wr_idx, input logic [15:0] wr_val,
                         input bit poke_b, output int lat);
        lat = 0;
        bus.start = 1'b1; bus.rn = rn; bus.rm = rm; bus.shift = sh;
        bus.asel = as; bus.bsel = bs; bus.imm = im;
        for (int e = 1; e <= 12; e++) begin
            @(posedge clk); #1;
            if (e == 1) begin
                bus.start = 1'b0;
                if (wr_a) begin
                    bus.write = 1'b1; bus.writenum = wr_idx; bus.data_in = wr_val;
                end
            end else if (e == 2) begin
                bus.write = 1'b0;
                if (poke_b) begin
                    bus.start = 1'b1; bus.rn = 3'd5; bus.rm = 3'd6;
                end
            end else if (e == 3) begin
                bus.start = 1'b0;
            end
            if (bus.out_valid) begin
                lat = e;
                break;
            end
        end
        bus.start = 1'b0;
        bus.write = 1'b0;
    endtask

    task automatic handshake_done(input string name);
        @(posedge clk); #1;
        chk({name, "_busy_after"}, {31'd0, bus.busy}, 32'd0);
    endtask

    int lat;
    int nv;

    initial begin
        bus.write = 0; bus.writenum = 0; bus.data_in = 0; bus.start = 0;
        bus.rn = 0; bus.rm = 0; bus.shift = 0; bus.asel = 0; bus.bsel = 0; bus.imm = 0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_ain", {16'd0, bus.Ain}, 32'd0);
        chk("rst_bin", {16'd0, bus.Bin}, 32'd0);
        chk_on = 1'b1;

        wr(3'd1, 16'd101);
        wr(3'd2, 16'd100);
        wr(3'd3, 16'h8001);
        wr(3'd4, 16'd3);

        // basic add-style fetch
        fetch(3'd1, 3'd2, 2'b00, 0, 0, 5'd0, 0, 3'd0, 16'd0, 0, lat);
        chk("basic_lat", lat, 32'd3);
        chk("basic_ain", {16'd0, bus.Ain}, 32'd101);
        chk("basic_bin", {16'd0, bus.Bin}, 32'd100);
        handshake_done("basic");

        // shifts on 0x8001
        fetch(3'd1, 3'd3, 2'b01, 0, 0, 5'd0, 0, 3'd0, 16'd0, 0, lat);
        chk("lsl_bin", {16'd0, bus.Bin}, 32'h0002);
        handshake_done("lsl");
        fetch(3'd1, 3'd3, 2'b10, 0, 0, 5'd0, 0, 3'd0, 16'd0, 0, lat);
        chk("lsr_bin", {16'd0, bus.Bin}, 32'h4000);
        handshake_done("lsr");
        fetch(3'd1, 3'd3, 2'b11, 0, 0, 5'd0, 0, 3'd0, 16'd0, 0, lat);
        chk("asr_bin", {16'd0, bus.Bin}, 32'hC000);
        chk("asr_ain", {16'd0, bus.Ain}, 32'd101);
        handshake_done("asr");

        // asel/bsel with backpressure
        bus.out_ready = 1'b0;
        fetch(3'd1, 3'd2, 2'b00, 1, 1, 5'd21, 0, 3'd0, 16'd0, 0, lat);
        chk("sel_lat", lat, 32'd3);
        chk("sel_ain", {16'd0, bus.Ain}, 32'd0);
        chk("sel_bin", {16'd0, bus.Bin}, 32'd21);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", {31'd0, bus.out_valid}, 32'd1);
            chk("hold_ain", {16'd0, bus.Ain}, 32'd0);
            chk("hold_bin", {16'd0, bus.Bin}, 32'd21);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("release_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("release_busy", {31'd0, bus.busy}, 32'd0);

        // write to R4 (currently 3) in the same cycle READ_A reads it
        fetch(3'd4, 3'd2, 2'b00, 0, 0, 5'd0, 1, 3'd4, 16'd7, 0, lat);
`ifdef OPERAND_FETCH_BYPASS_EN
        chk("rw_ain", {16'd0, bus.Ain}, 32'd7);
`else
        chk("rw_ain", {16'd0, bus.Ain}, 32'd3);
`endif
        chk("rw_bin", {16'd0, bus.Bin}, 32'd100);
        handshake_done("rw");

        // start pulsed during READ_B must be dropped
        fetch(3'd1, 3'd2, 2'b00, 0, 0, 5'd0, 0, 3'd0, 16'd0, 1, lat);
        chk("poke_ain", {16'd0, bus.Ain}, 32'd101);
        chk("poke_bin", {16'd0, bus.Bin}, 32'd100);
        nv = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid) nv++;
        end
        chk("poke_extra_valids", nv, 32'd0);

        // last of two back-to-back writes wins; rn==rm reads the same register
        wr(3'd5, 16'd9);
        wr(3'd5, 16'd10);
        fetch(3'd5, 3'd5, 2'b01, 0, 0, 5'd0, 0, 3'd0, 16'd0, 0, lat);
        chk("ww_ain", {16'd0, bus.Ain}, 32'd10);
        chk("ww_bin", {16'd0, bus.Bin}, 32'd20);
        handshake_done("ww");

        // reset during READ_B; write/start in the reset cycle are ignored
        bus.rn = 3'd1; bus.rm = 3'd2; bus.shift = 2'b00; bus.asel = 0; bus.bsel = 0;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        bus.write = 1'b1; bus.writenum = 3'd1; bus.data_in = 16'd55; bus.start = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        bus.write = 1'b0; bus.start = 1'b0;
        chk("abort_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("abort_busy", {31'd0, bus.busy}, 32'd0);
        fetch(3'd1, 3'd2, 2'b00, 0, 0, 5'd0, 0, 3'd0, 16'd0, 0, lat);
        chk("clr_lat", lat, 32'd3);
        chk("clr_ain", {16'd0, bus.Ain}, 32'd0);
        chk("clr_bin", {16'd0, bus.Bin}, 32'd0);
        handshake_done("clr");
        fetch(3'd4, 3'd3, 2'b00, 0, 0, 5'd0, 0, 3'd0, 16'd0, 0, lat);
        chk("clr2_ain", {16'd0, bus.Ain}, 32'd0);
        chk("clr2_bin", {16'd0, bus.Bin}, 32'd0);
        handshake_done("clr2");

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, expected finish before 100000");
        $fatal(1, "watchdog expired");
    end

endmodule
